// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signals of the ram_arbiter, grouped as one bundle.
// slave = arbiter side, master = requesters/RAM/bench side.
interface ram_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 24
);
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_lock;
    logic          r0_gnt;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;

    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_lock;
    logic          r1_gnt;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;

    logic [AW-1:0] ram_A;
    logic          ram_WE;
    logic          ram_OE;
    logic [DW-1:0] ram_D;
    logic [DW-1:0] ram_Q;

    logic [15:0]   stat0;
    logic [15:0]   stat1;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
        output r1_gnt, r1_rvalid, r1_rdata,
        output ram_A, ram_WE, ram_OE, ram_D,
        input  ram_Q,
        output stat0, stat1
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  ram_A, ram_WE, ram_OE, ram_D,
        output ram_Q,
        input  stat0, stat1
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter with lock for a single-port synchronous RAM.
// Define RAM_ARB_STAT_EN to build the saturating per-requester grant counters.
//
// state | meaning
// IDLE  | round-robin between r0/r1, rr pointer breaks ties
// LOCK0 | r0 owns the RAM until it makes an unlocked access
// LOCK1 | r1 owns the RAM until it makes an unlocked access
module ram_arbiter #(
    parameter int AW = 16,
    parameter int DW = 24
) (
    input  logic          CK,
    input  logic          RST,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;
    logic          gnt0, gnt1;

    logic          rd1_vld_q, rd1_vld_d;
    logic          rd1_own_q, rd1_own_d;
    logic          rd2_vld_q, rd2_vld_d;
    logic          rd2_own_q, rd2_own_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.r0_req && bus.r1_req) begin
                    gnt0 = ~rr_q;
                    gnt1 = rr_q;
                end else begin
                    gnt0 = bus.r0_req;
                    gnt1 = bus.r1_req;
                end
            end
            LOCK0:   gnt0 = bus.r0_req;
            LOCK1:   gnt1 = bus.r1_req;
            default: ;
        endcase

        if (RST) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        if (gnt0) begin
            rr_d    = 1'b1;
            state_d = bus.r0_lock ? LOCK0 : IDLE;
        end else if (gnt1) begin
            rr_d    = 1'b0;
            state_d = bus.r1_lock ? LOCK1 : IDLE;
        end
    end

    always_comb begin
        bus.ram_A  = '0;
        bus.ram_D  = '0;
        bus.ram_WE = 1'b0;
        if (gnt0) begin
            bus.ram_A  = bus.r0_addr;
            bus.ram_D  = bus.r0_wdata;
            bus.ram_WE = bus.r0_we;
        end else if (gnt1) begin
            bus.ram_A  = bus.r1_addr;
            bus.ram_D  = bus.r1_wdata;
            bus.ram_WE = bus.r1_we;
        end
    end

    // Stage 1: RAM drives Q for last cycle's read; stage 2: rvalid to the owner.
    always_comb begin
        rd1_vld_d = (gnt0 && !bus.r0_we) || (gnt1 && !bus.r1_we);
        rd1_own_d = gnt1;
        rd2_vld_d = rd1_vld_q;
        rd2_own_d = rd1_own_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (rd1_vld_q && !rd1_own_q) rdata0_d = bus.ram_Q;
        if (rd1_vld_q &&  rd1_own_q) rdata1_d = bus.ram_Q;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            rd1_vld_q <= 1'b0;
            rd1_own_q <= 1'b0;
            rd2_vld_q <= 1'b0;
            rd2_own_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            rd1_vld_q <= rd1_vld_d;
            rd1_own_q <= rd1_own_d;
            rd2_vld_q <= rd2_vld_d;
            rd2_own_q <= rd2_own_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign bus.r0_gnt    = gnt0;
    assign bus.r1_gnt    = gnt1;
    assign bus.ram_OE    = rd1_vld_q;
    assign bus.r0_rvalid = rd2_vld_q && !rd2_own_q;
    assign bus.r1_rvalid = rd2_vld_q &&  rd2_own_q;
    assign bus.r0_rdata  = rdata0_q;
    assign bus.r1_rdata  = rdata1_q;

`ifdef RAM_ARB_STAT_EN
    logic [15:0] stat0_q, stat0_d;
    logic [15:0] stat1_q, stat1_d;

    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (gnt0 && stat0_q != 16'hFFFF) stat0_d = stat0_q + 16'd1;
        if (gnt1 && stat1_q != 16'hFFFF) stat1_d = stat1_q + 16'd1;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign bus.stat0 = stat0_q;
    assign bus.stat1 = stat1_q;
`else
    assign bus.stat0 = 16'h0000;
    assign bus.stat1 = 16'h0000;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, per-cycle reference model compare, directed phases.
// Honours RAM_ARB_STAT_EN for the grant-counter expectations.
module tb_ram_arbiter;

    logic CK;
    logic RST;

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM: write and address latch on CK, Q valid only while OE is high
    logic [23:0] mem [0:65535];
    logic [15:0] a_lat;
    always @(posedge CK) begin
        if (bus.ram_WE) mem[bus.ram_A] <= bus.ram_D;
        a_lat <= bus.ram_A;
    end
    assign bus.ram_Q = bus.ram_OE ? mem[a_lat] : 24'hBADBAD;

    // Reference model
    typedef struct {
        int          due;
        int          owner;
        logic [23:0] data;
    } rd_t;

    rd_t         rq[$];
    logic [23:0] mm [int];
    int          cyc        = 0;
    int          rr         = 0;
    int          lock_owner = -1;
    logic        prev_rd    = 1'b0;
    logic        ev  [2];
    logic [23:0] er  [2] = '{24'h0, 24'h0};
    int          es  [2] = '{0, 0};
    logic        mreq [2];
    logic        mwe  [2];
    logic        mlk  [2];
    logic [15:0] maddr[2];
    logic [23:0] mwd  [2];
    int          g;

    function automatic int pick();
        if (RST) return -1;
        if (lock_owner >= 0) return mreq[lock_owner] ? lock_owner : -1;
        if (mreq[0] && mreq[1]) return rr;
        if (mreq[0]) return 0;
        if (mreq[1]) return 1;
        return -1;
    endfunction

    always @(negedge CK) begin
        mreq[0] = bus.r0_req;  mwe[0] = bus.r0_we;  mlk[0] = bus.r0_lock;
        maddr[0] = bus.r0_addr; mwd[0] = bus.r0_wdata;
        mreq[1] = bus.r1_req;  mwe[1] = bus.r1_we;  mlk[1] = bus.r1_lock;
        maddr[1] = bus.r1_addr; mwd[1] = bus.r1_wdata;

        ev[0] = 1'b0;
        ev[1] = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ev[rq[0].owner] = 1'b1;
            er[rq[0].owner] = rq[0].data;
            void'(rq.pop_front());
        end
        g = pick();

        chk("m_r0_gnt",    32'(bus.r0_gnt),    32'(g == 0));
        chk("m_r1_gnt",    32'(bus.r1_gnt),    32'(g == 1));
        chk("m_ram_WE",    32'(bus.ram_WE),    (g >= 0) ? 32'(mwe[g])   : 32'h0);
        chk("m_ram_A",     32'(bus.ram_A),     (g >= 0) ? 32'(maddr[g]) : 32'h0);
        chk("m_ram_D",     32'(bus.ram_D),     (g >= 0) ? 32'(mwd[g])   : 32'h0);
        chk("m_ram_OE",    32'(bus.ram_OE),    32'(prev_rd));
        chk("m_r0_rvalid", 32'(bus.r0_rvalid), 32'(ev[0]));
        chk("m_r1_rvalid", 32'(bus.r1_rvalid), 32'(ev[1]));
        chk("m_r0_rdata",  32'(bus.r0_rdata),  32'(er[0]));
        chk("m_r1_rdata",  32'(bus.r1_rdata),  32'(er[1]));
        chk("m_stat0",     32'(bus.stat0),     32'(es[0]));
        chk("m_stat1",     32'(bus.stat1),     32'(es[1]));

        if (RST) begin
            rr         = 0;
            lock_owner = -1;
            prev_rd    = 1'b0;
            rq.delete();
            er[0] = 24'h0;
            er[1] = 24'h0;
            es[0] = 0;
            es[1] = 0;
        end else begin
            prev_rd = (g >= 0) && !mwe[g];
            if (g >= 0) begin
                rr         = 1 - g;
                lock_owner = mlk[g] ? g : -1;
                if (mwe[g]) mm[int'(maddr[g])] = mwd[g];
                else rq.push_back('{due: cyc + 2, owner: g,
                                    data: mm.exists(int'(maddr[g])) ? mm[int'(maddr[g])] : 24'h0});
`ifdef RAM_ARB_STAT_EN
                if (es[g] < 65535) es[g]++;
`endif
            end
        end
        cyc++;
    end

    // Directed stimulus with hand-computed expectations
    task automatic nxt();
        @(posedge CK);
        #1;
    endtask

    task automatic set0(input logic req, input logic we, input logic lk,
                        input logic [15:0] a, input logic [23:0] d);
        bus.r0_req = req; bus.r0_we = we; bus.r0_lock = lk;
        bus.r0_addr = a;  bus.r0_wdata = d;
    endtask

    task automatic set1(input logic req, input logic we, input logic lk,
                        input logic [15:0] a, input logic [23:0] d);
        bus.r1_req = req; bus.r1_we = we; bus.r1_lock = lk;
        bus.r1_addr = a;  bus.r1_wdata = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int n0, n1;

    initial begin
        RST = 1'b1;
        set0(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        set1(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        nxt();
        nxt();
        RST = 1'b0;
        @(negedge CK);
        chk("rst_r0_gnt",    32'(bus.r0_gnt),    32'h0);
        chk("rst_ram_OE",    32'(bus.ram_OE),    32'h0);
        chk("rst_ram_A",     32'(bus.ram_A),     32'h0);
        chk("rst_r0_rvalid", 32'(bus.r0_rvalid), 32'h0);
        chk("rst_r1_rdata",  32'(bus.r1_rdata),  32'h0);
        nxt();

        // first tie after reset goes to r0
        set0(1'b1, 1'b1, 1'b0, 16'h0080, 24'h000111);
        set1(1'b1, 1'b1, 1'b0, 16'h0081, 24'h000222);
        @(negedge CK);
        chk("tie_r0_gnt", 32'(bus.r0_gnt), 32'h1);
        chk("tie_r1_gnt", 32'(bus.r1_gnt), 32'h0);
        nxt();
        set0(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        @(negedge CK);
        chk("tie2_r1_gnt", 32'(bus.r1_gnt), 32'h1);
        chk("tie2_ram_D",  32'(bus.ram_D),  32'h000222);
        nxt();
        set1(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);

        // write then read same address back-to-back
        set0(1'b1, 1'b1, 1'b0, 16'h0010, 24'hABCDEF);
        nxt();
        set0(1'b1, 1'b0, 1'b0, 16'h0010, 24'h0);
        @(negedge CK);
        chk("raw_rd_gnt", 32'(bus.r0_gnt), 32'h1);
        nxt();
        set0(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        @(negedge CK);
        chk("raw_oe", 32'(bus.ram_OE), 32'h1);
        nxt();
        @(negedge CK);
        chk("raw_rvalid", 32'(bus.r0_rvalid), 32'h1);
        chk("raw_rdata",  32'(bus.r0_rdata),  32'hABCDEF);
        chk("raw_r1_rv",  32'(bus.r1_rvalid), 32'h0);
        nxt();

        // r1 locked burst while r0 waits, including an idle locked cycle
        set1(1'b1, 1'b1, 1'b1, 16'h0040, 24'h111111);
        @(negedge CK);
        chk("lk1_r1_gnt", 32'(bus.r1_gnt), 32'h1);
        nxt();
        set1(1'b1, 1'b1, 1'b1, 16'h0041, 24'h222222);
        set0(1'b1, 1'b0, 1'b0, 16'h0010, 24'h0);
        @(negedge CK);
        chk("lk2_r1_gnt", 32'(bus.r1_gnt), 32'h1);
        chk("lk2_r0_gnt", 32'(bus.r0_gnt), 32'h0);
        nxt();
        set1(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        @(negedge CK);
        chk("lk_idle_r0_gnt", 32'(bus.r0_gnt), 32'h0);
        nxt();
        set1(1'b1, 1'b1, 1'b0, 16'h0042, 24'h333333);
        @(negedge CK);
        chk("lk3_r1_gnt", 32'(bus.r1_gnt), 32'h1);
        chk("lk3_r0_gnt", 32'(bus.r0_gnt), 32'h0);
        nxt();
        set1(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        @(negedge CK);
        chk("unlk_r0_gnt", 32'(bus.r0_gnt), 32'h1);
        nxt();

        // continuous reads from both; last grant was r0 so r1 goes first
        set0(1'b1, 1'b0, 1'b0, 16'h0010, 24'h0);
        set1(1'b1, 1'b0, 1'b0, 16'h0041, 24'h0);
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CK);
            if (i == 0) chk("rr_first_r1", 32'(bus.r1_gnt), 32'h1);
            if (i == 2) chk("rr_r1_rdata", 32'(bus.r1_rdata), 32'h222222);
            if (i == 3) chk("rr_r0_rdata", 32'(bus.r0_rdata), 32'hABCDEF);
            n0 += int'(bus.r0_gnt);
            n1 += int'(bus.r1_gnt);
            nxt();
        end
        chk("rr_n0", 32'(n0), 32'd4);
        chk("rr_n1", 32'(n1), 32'd4);
        set0(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        set1(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        nxt();
        nxt();
        nxt();

        // reset the cycle after a locked read grant
        set1(1'b1, 1'b0, 1'b1, 16'h0040, 24'h0);
        @(negedge CK);
        chk("mid_r1_gnt", 32'(bus.r1_gnt), 32'h1);
        nxt();
        set1(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        RST = 1'b1;
        nxt();
        RST = 1'b0;
        @(negedge CK);
        chk("mid_r1_rvalid", 32'(bus.r1_rvalid), 32'h0);
        chk("mid_r1_rdata",  32'(bus.r1_rdata),  32'h0);
        nxt();
        set0(1'b1, 1'b1, 1'b0, 16'h0090, 24'h000999);
        set1(1'b1, 1'b1, 1'b0, 16'h0091, 24'h000888);
        @(negedge CK);
        chk("post_rst_r0_gnt", 32'(bus.r0_gnt), 32'h1);
        nxt();
        set0(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        @(negedge CK);
        chk("post_rst_r1_gnt", 32'(bus.r1_gnt), 32'h1);
        nxt();
        set1(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);

`ifdef RAM_ARB_STAT_EN
        RST = 1'b1;
        nxt();
        RST = 1'b0;
        set0(1'b1, 1'b1, 1'b0, 16'h0100, 24'h00AAAA);
        repeat (70000) nxt();
        set0(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        @(negedge CK);
        chk("stat0_sat", 32'(bus.stat0), 32'h0000FFFF);
        chk("stat1_zero", 32'(bus.stat1), 32'h0);
`else
        @(negedge CK);
        chk("stat0_off", 32'(bus.stat0), 32'h0);
        chk("stat1_off", 32'(bus.stat1), 32'h0);
`endif
        nxt();
        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
